hazard_pipe_reg: RTL

- Parametrised inter-stage pipeline register with a built-in load-use hazard interlock.
- Captures one instruction slot per cycle (control/data payload plus destination register info) from stage N into stage N+1.
- Detects read-after-write hazards on any of NUM_SRC source operands against a long-latency producer in the output slot.
- Holds upstream for a configurable number of bubble cycles; supports flush and a downstream hold.

---
 rtl/hazard_pipe_reg.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/hazard_pipe_reg.sv
// hazard_pipe_reg
// ---------------------------------------------------------------------------
// Register between two pipeline stages. It moves one instruction slot per
// cycle from stage N to stage N+1. It also has a load-use interlock: when the
// instruction in the output slot produces its result late (a load or a
// system-register read), a consumer that arrives the next cycle is held
// upstream. The register inserts LOAD_STALL bubbles before it accepts that
// consumer.
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   in_valid             upstream slot holds a real instruction
//   in_payload           opaque payload carried to the next stage
//   in_wr_idx/in_wr_en   destination register index / write enable
//   in_is_load           result is late; dependent instructions must wait
//   in_rd_idx/in_rd_used source indices (packed, REG_IDX_W each) / use flags
//   flush                kill the incoming instruction (a bubble is written)
//   ext_stall            downstream cannot accept; all outputs hold
//   out_*                registered slot; wr_en and is_load are already
//                        gated by valid
//   stall                upstream must hold its inputs this cycle
//   hazard_src           combinational per-source hazard match
//   stall_cycles         saturating count of inserted hazard bubbles
// ---------------------------------------------------------------------------
module hazard_pipe_reg #(
    parameter int PAYLOAD_W  = 32,
    parameter int REG_IDX_W  = 4,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_STALL = 1,
    parameter int IGNORE_R0  = 0,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [PAYLOAD_W-1:0]         in_payload,
    input  logic [REG_IDX_W-1:0]         in_wr_idx,
    input  logic                         in_wr_en,
    input  logic                         in_is_load,
    input  logic [NUM_SRC*REG_IDX_W-1:0] in_rd_idx,
    input  logic [NUM_SRC-1:0]           in_rd_used,
    input  logic                         flush,
    input  logic                         ext_stall,
    output logic                         out_valid,
    output logic [PAYLOAD_W-1:0]         out_payload,
    output logic [REG_IDX_W-1:0]         out_wr_idx,
    output logic                         out_wr_en,
    output logic                         out_is_load,
    output logic                         stall,
    output logic [NUM_SRC-1:0]           hazard_src,
    output logic [CNT_W-1:0]             stall_cycles
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } stateT;

    // LOAD_STALL is limited to 1..15, so 4 bits hold the remaining count.
    localparam logic [3:0] STALL_INIT = 4'(LOAD_STALL - 1);

    stateT                 stateReg, stateNext;
    logic [3:0]            cntReg, cntNext;
    logic                  validReg, validNext;
    logic [PAYLOAD_W-1:0]  payloadReg, payloadNext;
    logic [REG_IDX_W-1:0]  wrIdxReg, wrIdxNext;
    logic                  wrEnReg, wrEnNext;
    logic                  isLoadReg, isLoadNext;
    logic [CNT_W-1:0]      stallCntReg, stallCntNext;
    logic [CNT_W-1:0]      stallCntInc;
    logic [NUM_SRC-1:0]    hazardRaw;
    logic                  hazard;

    // A hazard needs a valid late-result producer in the output slot. The
    // check runs only in RUN, so the bubble that follows a stall can never
    // start a second stall.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [REG_IDX_W-1:0] srcIdx;
            logic                 r0Skip;
            assign srcIdx = in_rd_idx[gi*REG_IDX_W +: REG_IDX_W];
            assign r0Skip = (IGNORE_R0 != 0) && (srcIdx == '0);
            assign hazardRaw[gi] = (stateReg == RUN) && validReg && wrEnReg &&
                                   isLoadReg && in_valid && in_rd_used[gi] &&
                                   (srcIdx == wrIdxReg) && !r0Skip;
        end
    endgenerate

    assign hazard_src = (flush || reset) ? '0 : hazardRaw;
    assign hazard     = |hazard_src;

    assign stallCntInc = (stallCntReg == '1) ? stallCntReg
                                             : stallCntReg + CNT_W'(1);

    always_comb begin
        stateNext    = stateReg;
        cntNext      = cntReg;
        validNext    = validReg;
        payloadNext  = payloadReg;
        wrIdxNext    = wrIdxReg;
        wrEnNext     = wrEnReg;
        isLoadNext   = isLoadReg;
        stallCntNext = stallCntReg;
        stall        = 1'b0;

        if (reset) begin
            stall = 1'b0;
        end else if (flush) begin
            // Bubble: the index and payload hold, so only the qualifiers drop.
            validNext  = 1'b0;
            wrEnNext   = 1'b0;
            isLoadNext = 1'b0;
            stateNext  = RUN;
            cntNext    = '0;
        end else if (ext_stall) begin
            stall = 1'b1;
        end else if (stateReg == RUN && hazard) begin
            stall        = 1'b1;
            validNext    = 1'b0;
            wrEnNext     = 1'b0;
            isLoadNext   = 1'b0;
            stateNext    = STALL;
            cntNext      = STALL_INIT;
            stallCntNext = stallCntInc;
        end else if (stateReg == STALL && cntReg != '0) begin
            stall        = 1'b1;
            validNext    = 1'b0;
            wrEnNext     = 1'b0;
            isLoadNext   = 1'b0;
            cntNext      = cntReg - 4'd1;
            stallCntNext = stallCntInc;
        end else begin
            validNext  = in_valid;
            wrEnNext   = in_valid & in_wr_en;
            isLoadNext = in_valid & in_is_load;
            wrIdxNext  = in_wr_idx;
            if (in_valid) begin
                payloadNext = in_payload;
            end
            stateNext = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg    <= RUN;
            cntReg      <= '0;
            validReg    <= 1'b0;
            payloadReg  <= '0;
            wrIdxReg    <= '0;
            wrEnReg     <= 1'b0;
            isLoadReg   <= 1'b0;
            stallCntReg <= '0;
        end else begin
            stateReg    <= stateNext;
            cntReg      <= cntNext;
            validReg    <= validNext;
            payloadReg  <= payloadNext;
            wrIdxReg    <= wrIdxNext;
            wrEnReg     <= wrEnNext;
            isLoadReg   <= isLoadNext;
            stallCntReg <= stallCntNext;
        end
    end

    assign out_valid    = validReg;
    assign out_payload  = payloadReg;
    assign out_wr_idx   = wrIdxReg;
    assign out_wr_en    = wrEnReg;
    assign out_is_load  = isLoadReg;
    assign stall_cycles = stallCntReg;

endmodule
